sc_stream_encoder: RTL and testbench
====================================

// Module: sc_stream_encoder
// PURPOSE
//  Binary-to-stochastic encoder: converts a WIDTH+1-bit magnitude into a unipolar
//  bitstream frame of 2^WIDTH bits containing exactly that many ones.
//  Transmit end of the stochastic link whose receive end counts ones per 2^WIDTH window.
//  Values arrive on a valid/ready handshake. A one-deep pending buffer lets frames
//  stream back-to-back with no gap.
// PARAMETERS
//  WIDTH     5     frame length = 2^WIDTH; legal 3..8
//  SEQ_MODE  0     0 = bit-reversed frame counter (van der Corput); 1 = maximal LFSR
//  LFSR_SEED 1     LFSR load value at each frame start; nonzero, WIDTH bits
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, asynchronous, active-high
//  in_value     in   WIDTH+1  ones per frame; values > 2^WIDTH saturate to 2^WIDTH
//  in_valid     in   1        in_value valid
//  in_ready     out  1        = ~pend_valid; accept on edge where in_valid & in_ready
//  en           in   1        stream enable; 0 stalls the frame in place
//  out_bit      out  1        stochastic bit, registered
//  out_valid    out  1        out_bit carries a frame bit this cycle
//  frame_start  out  1        with out_valid: bit index 0 of a frame
//  frame_last   out  1        with out_valid: bit index 2^WIDTH-1
//  frame_ones   out  WIDTH+1  ones emitted so far in current frame, incl. out_bit
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, active=0, pend_valid=0, lfsr=LFSR_SEED.
//   Outputs during and after reset: out_bit, out_valid, frame_start, frame_last = 0;
//   frame_ones = 0; in_ready = 1 once rst deasserts.
//  Registers: active value, pending value + pend_valid, cnt[WIDTH-1:0], lfsr[WIDTH-1:0].
//  Sequence word:
//   mode 0: seq = bitrev(cnt).
//   mode 1: seq = (cnt==0) ? 0 : lfsr; lfsr = LFSR_SEED at index 0, steps once per bit.
//   Taps are maximal-length Fibonacci: w3:3,2 w4:4,3 w5:5,3 w6:6,5 w7:7,6 w8:8,6,5,4.
//   Both modes visit every value 0..2^WIDTH-1 exactly once per frame.
//  Bit rule: out_bit = (seq < active), WIDTH+1-bit compare.
//   Ones per frame = active exactly; value 0 -> all zeros; 2^WIDTH -> all ones.
//  FSM IDLE:
//   Accept loads active (saturated), cnt=0, then RUN. out_valid=0 in IDLE.
//   Latency: accept on edge k -> index 0 registered on the first edge > k with en=1.
//  FSM RUN, each edge with en=1:
//   Register out_bit/out_valid=1/flags for index cnt, update frame_ones, cnt++.
//   At cnt==2^WIDTH-1 (frame_last): if pending held, or in_valid & in_ready on this
//   edge, next value becomes active, cnt wraps to 0, stays RUN (no gap).
//   Otherwise goes IDLE; out_valid drops after the last bit.
//  RUN, en=0: cnt, lfsr and active hold; out_valid=0; frame resumes seamlessly on en=1.
//  Handshake in RUN: accept writes the pending buffer; in_ready falls the next cycle.
//   Simultaneous accept and frame wrap: the value bypasses pending straight to active;
//   pend_valid stays 0.
//  frame_ones resets to out_bit at each frame_start; equals active at frame_last.
//  rst mid-frame: frame aborted, pending dropped, all state to reset values immediately.
// TESTING (WIDTH=5, frame = 32 bits)
//  1 Mode 0, value 0, 1, 16, 31, 32 -> ones per frame 0, 1, 16, 31, 32; frame_ones at
//    frame_last matches. Value 16 -> bits alternate 1,0,1,0.
//  2 Mode 1, seed 1, values 0..32 sweep -> every frame has ones == value, 32 bits long.
//    Each frame starts with seq 0, so bit 0 = 1 iff value > 0.
//  3 Values 10 then 20 with in_valid held -> second accepted during frame 1.
//    frame_last then frame_start on consecutive cycles; ones 10 then 20; in_ready 0
//    while pending.
//  4 en toggled 1-0-1 every 3 cycles, value 7 -> 32 valid bits total, 7 ones;
//    out_valid 0 on every stalled cycle.
//  5 in_value 40 -> saturates: 32 ones; value 5 offered on the frame_last edge with
//    pending empty -> next frame starts with no gap, 5 ones.
//  6 rst pulse at bit 12 of a frame with a pending value -> out_valid, pend_valid 0.
//    in_ready 1 after release; no bits until a new accept.

Source files
------------

// File: rtl/sc_stream_encoder.sv
// Binary-to-stochastic encoder: turns a magnitude into a 2^WIDTH-bit unipolar
// frame holding exactly that many ones, fed through a valid/ready handshake
// with a one-deep pending buffer so frames can run back-to-back.
module sc_stream_encoder #(
  parameter int unsigned      WIDTH     = 5,
  parameter int unsigned      SEQ_MODE  = 0,
  parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:0]   in_value,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             out_bit,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic [WIDTH:0]   frame_ones
);

  localparam logic [WIDTH:0]   FULL     = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   active_q, active_d;
  logic [WIDTH:0]   pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_last_q, frame_last_d;
  logic [WIDTH:0]   frame_ones_q, frame_ones_d;

  logic [WIDTH-1:0] seq;
  logic             bit_now;
  logic             accept;
  logic             wrap;
  logic [WIDTH:0]   in_sat;

  // Maximal-length Fibonacci step; state is widened to 8 bits so every tap
  // index stays in range whatever WIDTH is.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [7:0] x;
    logic       fb;
    x = 8'(s);
    case (WIDTH)
      3:       fb = x[2] ^ x[1];
      4:       fb = x[3] ^ x[2];
      5:       fb = x[4] ^ x[2];
      6:       fb = x[5] ^ x[4];
      7:       fb = x[6] ^ x[5];
      default: fb = x[7] ^ x[5] ^ x[4] ^ x[3];
    endcase
    return {s[WIDTH-2:0], fb};
  endfunction

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) r[i] = c[WIDTH-1-i];
    return r;
  endfunction

  // Sequence word, bit decision and handshake qualifiers
  always_comb begin
    if (SEQ_MODE == 0) seq = bitrev(cnt_q);
    else               seq = (cnt_q == '0) ? '0 : lfsr_q;
    bit_now = ({1'b0, seq} < active_q);
    accept  = in_valid & ~pend_valid_q;
    wrap    = (state_q == S_RUN) && en && (cnt_q == CNT_LAST);
    in_sat  = (in_value > FULL) ? FULL : in_value;
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    out_bit_d     = 1'b0;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_last_d  = 1'b0;
    frame_ones_d  = frame_ones_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          active_d = in_sat;
          cnt_d    = '0;
          lfsr_d   = LFSR_SEED;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (en) begin
          out_bit_d     = bit_now;
          out_valid_d   = 1'b1;
          frame_start_d = (cnt_q == '0);
          frame_last_d  = (cnt_q == CNT_LAST);
          frame_ones_d  = (cnt_q == '0) ? (WIDTH+1)'(bit_now)
                                        : frame_ones_q + (WIDTH+1)'(bit_now);
          cnt_d         = cnt_q + 1'b1;
          lfsr_d        = lfsr_step(lfsr_q);
        end
        // A value arriving on the wrap edge skips the pending buffer.
        if (wrap) begin
          lfsr_d = LFSR_SEED;
          if (pend_valid_q) begin
            active_d     = pend_q;
            pend_valid_d = 1'b0;
          end else if (accept) begin
            active_d = in_sat;
          end else begin
            state_d = S_IDLE;
          end
        end else if (accept) begin
          pend_d       = in_sat;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      active_q      <= '0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      cnt_q         <= '0;
      lfsr_q        <= LFSR_SEED;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
      frame_ones_q  <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      out_bit_q     <= out_bit_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
      frame_ones_q  <= frame_ones_d;
    end
  end

  assign in_ready    = ~pend_valid_q;
  assign out_bit     = out_bit_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;
  assign frame_ones  = frame_ones_q;

endmodule

// File: tb/tb_sc_stream_encoder.sv
// Directed bench for sc_stream_encoder: one bit-reversed and one LFSR instance
// share the same stimulus; a monitor collects each completed frame.
module tb_sc_stream_encoder;

  logic       clk;
  logic       rst;
  logic [5:0] in_value;
  logic       in_valid;
  logic       en = 1'b1;
  logic       toggle_en;
  logic [1:0] ir, ob, ov, fs, fl;
  logic [5:0] fo [2];

  int errors = 0;
  int checks = 0;

  sc_stream_encoder #(.WIDTH(5), .SEQ_MODE(0), .LFSR_SEED(5'd1)) u_dut0 (
    .clk(clk), .rst(rst), .in_value(in_value), .in_valid(in_valid),
    .in_ready(ir[0]), .en(en), .out_bit(ob[0]), .out_valid(ov[0]),
    .frame_start(fs[0]), .frame_last(fl[0]), .frame_ones(fo[0]));

  sc_stream_encoder #(.WIDTH(5), .SEQ_MODE(1), .LFSR_SEED(5'd1)) u_dut1 (
    .clk(clk), .rst(rst), .in_value(in_value), .in_valid(in_valid),
    .in_ready(ir[1]), .en(en), .out_bit(ob[1]), .out_valid(ov[1]),
    .frame_start(fs[1]), .frame_last(fl[1]), .frame_ones(fo[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          ones;
    int          len;
    int          fones;
    logic [31:0] pat;
    int          gap;
  } frame_rec_t;

  typedef struct {
    logic [5:0]  value;
    int          exp_ones;
    logic [31:0] exp_pat;
    bit          chk_pat;
  } vec_t;

  frame_rec_t  rq0[$];
  frame_rec_t  rq1[$];
  int          cyc = 0;
  int          stall_bad = 0;
  int          vcount = 0;
  int          tcnt = 0;
  int          ones_a[2], len_a[2], last_a[2], gap_a[2];
  logic [31:0] pat_a[2];

  // Stream enable: steady high, or 3-high/3-low when toggling is requested
  always @(negedge clk) begin
    tcnt++;
    en = toggle_en ? (((tcnt / 3) % 2) == 0) : 1'b1;
  end

  // Frame collector, sampling 1 time unit after each rising edge
  always @(posedge clk) begin
    logic en_s;
    frame_rec_t rec;
    en_s = en;
    #1;
    cyc++;
    if (!en_s && ov[0]) stall_bad++;
    if (ov[0]) vcount++;
    for (int d = 0; d < 2; d++) begin
      if (ov[d]) begin
        if (fs[d]) begin
          ones_a[d] = 0;
          len_a[d]  = 0;
          pat_a[d]  = '0;
          gap_a[d]  = cyc - last_a[d];
        end
        if (len_a[d] < 32) pat_a[d][len_a[d]] = ob[d];
        ones_a[d] += int'(ob[d]);
        len_a[d]++;
        if (fl[d]) begin
          rec.ones  = ones_a[d];
          rec.len   = len_a[d];
          rec.fones = int'(fo[d]);
          rec.pat   = pat_a[d];
          rec.gap   = gap_a[d];
          last_a[d] = cyc;
          if (d == 0) rq0.push_back(rec);
          else        rq1.push_back(rec);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Offer a value (called at a falling edge); returns at the falling edge after acceptance
  task automatic send(input logic [5:0] v);
    in_value = v;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (ir[0]) begin
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("send_timeout", 0, 1);
  endtask

  task automatic get_frames(output frame_rec_t r0, output frame_rec_t r1, output bit ok);
    int n = 0;
    while ((rq0.size() == 0 || rq1.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (rq0.size() > 0 && rq1.size() > 0);
    if (ok) begin
      r0 = rq0.pop_front();
      r1 = rq1.pop_front();
    end else begin
      r0 = '{default: 0};
      r1 = '{default: 0};
      chk("frame_timeout", 0, 1);
    end
  endtask

  initial begin
    vec_t       vecs[$];
    frame_rec_t r0, r1, r0b, r1b;
    bit         ok, okb;

    vecs.push_back('{6'd0,  0,  32'h0000_0000, 1'b1});
    vecs.push_back('{6'd1,  1,  32'h0000_0001, 1'b1});
    vecs.push_back('{6'd16, 16, 32'h5555_5555, 1'b1});
    vecs.push_back('{6'd31, 31, 32'h7FFF_FFFF, 1'b1});
    vecs.push_back('{6'd32, 32, 32'hFFFF_FFFF, 1'b1});
    for (int v = 0; v <= 32; v++) vecs.push_back('{6'(v), v, 32'h0, 1'b0});

    rst = 1'b1; in_valid = 1'b0; in_value = '0; toggle_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(ov), 0);
    chk("rst_out_bit", int'(ob), 0);
    chk("rst_flags", int'({fs, fl}), 0);
    chk("rst_frame_ones", int'(fo[0]) + int'(fo[1]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(ir), 3);

    // Single frames: exact ones, lengths and bit-reversed patterns
    foreach (vecs[i]) begin
      send(vecs[i].value);
      get_frames(r0, r1, ok);
      if (ok) begin
        chk($sformatf("m0_ones_v%0d", vecs[i].value), r0.ones, vecs[i].exp_ones);
        chk($sformatf("m0_len_v%0d", vecs[i].value), r0.len, 32);
        chk($sformatf("m0_fones_v%0d", vecs[i].value), r0.fones, vecs[i].exp_ones);
        if (vecs[i].chk_pat)
          chk($sformatf("m0_pat_v%0d", vecs[i].value), int'(r0.pat), int'(vecs[i].exp_pat));
        chk($sformatf("m1_ones_v%0d", vecs[i].value), r1.ones, vecs[i].exp_ones);
        chk($sformatf("m1_len_v%0d", vecs[i].value), r1.len, 32);
        chk($sformatf("m1_fones_v%0d", vecs[i].value), r1.fones, vecs[i].exp_ones);
        chk($sformatf("m1_bit0_v%0d", vecs[i].value), int'(r1.pat[0]),
            (vecs[i].exp_ones > 0) ? 1 : 0);
      end
    end

    // Back-to-back: 10 then 20 with in_valid held
    in_value = 6'd10; in_valid = 1'b1;
    @(negedge clk);
    in_value = 6'd20;
    @(negedge clk);
    chk("b2b_ready_pending", int'(ir[0]), 0);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("b2b_ready_mid", int'(ir[0]), 0);
    get_frames(r0, r1, ok);
    get_frames(r0b, r1b, okb);
    if (ok && okb) begin
      chk("b2b_ones_a", r0.ones, 10);
      chk("b2b_ones_b", r0b.ones, 20);
      chk("b2b_gap", r0b.gap, 1);
      chk("b2b_m1_ones_b", r1b.ones, 20);
      chk("b2b_ready_after", int'(ir[0]), 1);
    end

    // Enable toggling 3 on / 3 off
    stall_bad = 0;
    toggle_en = 1'b1;
    send(6'd7);
    get_frames(r0, r1, ok);
    toggle_en = 1'b0;
    if (ok) begin
      chk("stall_len", r0.len, 32);
      chk("stall_ones", r0.ones, 7);
      chk("stall_m1_ones", r1.ones, 7);
      chk("stall_out_valid", stall_bad, 0);
    end

    // Saturation, then a value offered exactly on the frame_last edge
    send(6'd40);
    repeat (31) @(negedge clk);
    in_value = 6'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bypass_ready", int'(ir[0]), 1);
    get_frames(r0, r1, ok);
    get_frames(r0b, r1b, okb);
    if (ok && okb) begin
      chk("sat_ones", r0.ones, 32);
      chk("sat_fones", r0.fones, 32);
      chk("bypass_ones", r0b.ones, 5);
      chk("bypass_gap", r0b.gap, 1);
      chk("bypass_m1_ones", r1b.ones, 5);
    end

    // Reset pulse mid-frame with a pending value
    send(6'd9);
    send(6'd3);
    chk("abort_pending", int'(ir[0]), 0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", int'(ov), 0);
    chk("abort_in_ready", int'(ir), 3);
    chk("abort_frame_ones", int'(fo[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_bits", vcount, 0);
    chk("abort_ready_after", int'(ir[0]), 1);
    chk("abort_no_frames", rq0.size() + rq1.size(), 0);
    send(6'd4);
    get_frames(r0, r1, ok);
    if (ok) begin
      chk("recover_ones", r0.ones, 4);
      chk("recover_m1_ones", r1.ones, 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
